// File: rtl/dds_pkg.sv
// Shared opcodes, response codes, parser state encoding and status-byte layout
// for the DDS command parser slice.
package dds_pkg;

  localparam logic [3:0] OP_LOAD    = 4'h1;
  localparam logic [3:0] OP_ENABLE  = 4'h2;
  localparam logic [3:0] OP_DISABLE = 4'h3;
  localparam logic [3:0] OP_SELECT  = 4'h4;
  localparam logic [3:0] OP_SET     = 4'h5;
  localparam logic [3:0] OP_STATUS  = 4'h6;

  localparam logic [7:0] ACK_BASE = 8'hA0;
  localparam logic [7:0] NAK      = 8'hEE;

  localparam int unsigned STAT_OVF = 7;
  localparam int unsigned STAT_TMO = 6;
  localparam int unsigned STAT_BAD = 5;

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [7:0] status_byte(input logic ovf, input logic tmo,
                                             input logic bad, input logic [3:0] sel);
    logic [7:0] b;
    b           = '0;
    b[STAT_OVF] = ovf;
    b[STAT_TMO] = tmo;
    b[STAT_BAD] = bad;
    b[3:0]      = sel;
    return b;
  endfunction

endpackage

// File: rtl/dds_word_bank.sv
// Per-channel shadow/active tuning words: byte-wise shadow writes, atomic
// commit of one channel's shadow into its active word with a one-cycle strobe.
module dds_word_bank
  import dds_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned N_CHANNELS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_wr_en,
  input  logic [3:0]                       i_wr_ch,
  input  logic [3:0]                       i_wr_idx,
  input  logic [7:0]                       i_wr_data,
  input  logic                             i_commit_en,
  input  logic [3:0]                       i_commit_ch,
  output logic [N_CHANNELS*WORD_BYTES*8-1:0] o_m,
  output logic [N_CHANNELS-1:0]            o_set
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;

  logic [N_CHANNELS-1:0][WORD_W-1:0] r_shadow;
  logic [N_CHANNELS-1:0][WORD_W-1:0] r_m;
  logic [N_CHANNELS-1:0]             r_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_m      <= '0;
      r_set    <= '0;
    end else begin
      r_set <= '0;
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
          if (i_wr_en && (i_wr_ch == 4'(c)) && (i_wr_idx == 4'(b)))
            r_shadow[c][b*8 +: 8] <= i_wr_data;
        end
        if (i_commit_en && (i_commit_ch == 4'(c))) begin
          r_m[c]   <= r_shadow[c];
          r_set[c] <= 1'b1;
        end
      end
    end
  end

  assign o_m   = r_m;
  assign o_set = r_set;

endmodule

// File: rtl/dds_cmd_parser.sv
// UART byte-stream command parser for the DDS core: opcode FSM, data timeout,
// status/ack holding register. Optional per-command acks under `CMD_ACK_EN.
module dds_cmd_parser
  import dds_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned N_CHANNELS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rx_valid,
  input  logic [7:0]                         rx_byte,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic [7:0]                         tx_byte,
  output logic [N_CHANNELS-1:0]              en,
  output logic [N_CHANNELS*WORD_BYTES*8-1:0] m,
  output logic [N_CHANNELS-1:0]              set
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t                r_state;
  logic [3:0]            r_sel;
  logic [3:0]            r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;
  logic                  r_tmo;
  logic                  r_bad;
  logic                  r_tx_valid;
  logic [7:0]            r_tx_byte;
  logic [N_CHANNELS-1:0] r_en;

  logic [3:0] w_op;
  logic [3:0] w_arg;
  logic       w_ch_ok;
  logic       w_idx_ok;
  logic       w_cmd;
  logic       w_cmd_ok;
  logic       w_wr;
  logic       w_commit;

  always_comb begin
    w_op     = rx_byte[7:4];
    w_arg    = rx_byte[3:0];
    w_ch_ok  = ({1'b0, w_arg} < 5'(N_CHANNELS));
    w_idx_ok = ({1'b0, w_arg} < 5'(WORD_BYTES));
    w_cmd    = (r_state == ST_CMD) && rx_valid;
    w_wr     = (r_state == ST_DATA) && rx_valid;
    w_commit = w_cmd && (w_op == OP_SET);
    case (w_op)
      OP_LOAD:                            w_cmd_ok = w_idx_ok;
      OP_ENABLE, OP_DISABLE, OP_SELECT:   w_cmd_ok = w_ch_ok;
      OP_SET, OP_STATUS:                  w_cmd_ok = 1'b1;
      default:                            w_cmd_ok = 1'b0;
    endcase
  end

`ifdef CMD_ACK_EN
  logic       w_ack_go;
  logic [7:0] w_ack_byte;

  // A good LOAD opcode is acknowledged only once its data byte lands.
  always_comb begin
    w_ack_go = w_wr ||
               (w_cmd && (w_op != OP_STATUS) && !((w_op == OP_LOAD) && w_cmd_ok));
    if (w_cmd && !w_cmd_ok)
      w_ack_byte = NAK;
    else
      w_ack_byte = ACK_BASE | {4'h0, (w_wr ? OP_LOAD : w_op)};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CMD;
      r_sel      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_tmo      <= 1'b0;
      r_bad      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= '0;
      r_en       <= '0;
    end else begin
      case (r_state)
        ST_CMD: begin
          if (rx_valid) begin
            if (!w_cmd_ok) begin
              r_bad <= 1'b1;
            end else begin
              case (w_op)
                OP_LOAD: begin
                  r_idx   <= w_arg;
                  r_cnt   <= '0;
                  r_state <= ST_DATA;
                end
                OP_ENABLE, OP_DISABLE: begin
                  for (int unsigned c = 0; c < N_CHANNELS; c++)
                    if (w_arg == 4'(c)) r_en[c] <= (w_op == OP_ENABLE);
                end
                OP_SELECT: r_sel <= w_arg;
                OP_STATUS: begin
                  // Flags are snapshotted and cleared together; none can be
                  // raised in CMD alongside a STATUS decode.
                  r_tx_byte  <= status_byte(r_ovf, r_tmo, r_bad, r_sel);
                  r_tx_valid <= 1'b1;
                  r_ovf      <= 1'b0;
                  r_tmo      <= 1'b0;
                  r_bad      <= 1'b0;
                  r_state    <= ST_RESP;
                end
                default: ;
              endcase
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            r_state <= ST_CMD;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_tmo   <= 1'b1;
            r_state <= ST_CMD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rx_valid) r_ovf <= 1'b1;
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_CMD;
          end
        end
        default: r_state <= ST_CMD;
      endcase

`ifdef CMD_ACK_EN
      if (w_ack_go) begin
        r_tx_byte  <= w_ack_byte;
        r_tx_valid <= 1'b1;
        r_state    <= ST_RESP;
      end
`endif
    end
  end

  dds_word_bank #(
    .WORD_BYTES (WORD_BYTES),
    .N_CHANNELS (N_CHANNELS)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr),
    .i_wr_ch     (r_sel),
    .i_wr_idx    (r_idx),
    .i_wr_data   (rx_byte),
    .i_commit_en (w_commit),
    .i_commit_ch (r_sel),
    .o_m         (m),
    .o_set       (set)
  );

  assign tx_valid = r_tx_valid;
  assign tx_byte  = r_tx_byte;
  assign en       = r_en;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser: tx bytes checked by a scoreboard monitor,
// word/enable/strobe state checked inline against hand-computed values.
module tb_dds_cmd_parser;

  localparam int unsigned WB = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [7:0]    tx_byte;
  logic [NC-1:0] en;
  logic [NC*WB*8-1:0] m;
  logic [NC-1:0] set;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_q[$];

  dds_cmd_parser #(
    .WORD_BYTES     (WB),
    .N_CHANNELS     (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .en       (en),
    .m        (m),
    .set      (set)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake will occur at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_byte !== e) begin
          errors++;
          $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_byte, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic status_cmd(input logic [7:0] exp);
    exp_q.push_back(exp);
    send(8'h60);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 tx_ready = r;
  endtask

  initial begin
    int unsigned guard;
    repeat (2) @(negedge clk);
    check("reset_en", 64'(en), 64'h0);
    check("reset_m", 64'(m), 64'h0);
    check("reset_set", 64'(set), 64'h0);
    check("reset_tx_valid", 64'(tx_valid), 64'h0);
    check("reset_tx_byte", 64'(tx_byte), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef CMD_ACK_EN
    exp_q.push_back(8'hA2); send(8'h21); @(negedge clk);
    check("ack_en", 64'(en), 64'h2);
    exp_q.push_back(8'hEE); send(8'h2F); @(negedge clk);
    send(8'h11);
    exp_q.push_back(8'hA1); send(8'h5A); @(negedge clk);
    status_cmd(8'h20);
`else
    // Load channel 0 with 0x12345678 and commit
    send(8'h40);
    send(8'h10); send(8'h78);
    send(8'h11); send(8'h56);
    send(8'h12); send(8'h34);
    send(8'h13); send(8'h12);
    check("shadow_not_active", 64'(m), 64'h0);
    send(8'h50);
    check("set_m0", 64'(m[31:0]), 64'h12345678);
    check("set_m1_untouched", 64'(m[63:32]), 64'h0);
    check("set_pulse", 64'(set), 64'h1);
    @(negedge clk);
    check("set_pulse_end", 64'(set), 64'h0);

    // Select ch1, enable ch1, disable ch0, STATUS held until ready
    send(8'h41); send(8'h21); send(8'h30);
    check("en_after_enable", 64'(en), 64'h2);
    set_ready(1'b0);
    exp_q.push_back(8'h01);
    send(8'h60);
    for (int i = 0; i < 3; i++) begin
      check("status_hold_valid", 64'(tx_valid), 64'h1);
      check("status_hold_byte", 64'(tx_byte), 64'h01);
      @(negedge clk);
    end
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("status_released", 64'(tx_valid), 64'h0);

    // LOAD then silence: timeout, following byte decoded as opcode
    send(8'h11);
    repeat (TO) @(negedge clk);
    send(8'h05);
    status_cmd(8'h61);
    send(8'h50);
    check("tmo_shadow_unchanged", 64'(m[63:32]), 64'h0);
    check("tmo_m0_kept", 64'(m[31:0]), 64'h12345678);
    check("tmo_set1", 64'(set), 64'h2);

    // Overflow: byte arriving while a response is pending is dropped
    set_ready(1'b0);
    exp_q.push_back(8'h01);
    send(8'h60);
    send(8'h20);
    check("ovf_en_unchanged", 64'(en), 64'h2);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    status_cmd(8'h81);
    status_cmd(8'h01);

    // Range errors: bad LOAD index must not enter DATA
    send(8'h14);
    send(8'h20);
    check("bad_idx_stays_cmd", 64'(en), 64'h3);
    send(8'h2F);
    check("bad_ch_en_unchanged", 64'(en), 64'h3);
    status_cmd(8'h21);

    // Asynchronous reset while in DATA
    send(8'h11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_data_en", 64'(en), 64'h0);
    check("rst_data_m", 64'(m), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while in RESP drops the pending byte
    send(8'h21);
    set_ready(1'b0);
    send(8'h60);
    check("resp_pending", 64'(tx_valid), 64'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp_tx_valid", 64'(tx_valid), 64'h0);
    check("rst_resp_tx_byte", 64'(tx_byte), 64'h0);
    check("rst_resp_en", 64'(en), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
`endif

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tx_missing: got %0d bytes outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
